regfile_scoreboard: RTL

Parametrised multi-read-port register file with a per-register pending-write scoreboard and optional write-to-read bypass. It replaces the plain two-port register file in the datapath for cores with multi-cycle units. The issue stage reserves a destination register, the writeback stage fills it, and the read ports report both data and a busy flag so the controller can stall on RAW hazards.

---
 rtl/regfile_scoreboard.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with a per-register pending-write scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef NUM_REGISTERS
`define NUM_REGISTERS 32
`endif

module regfile_scoreboard #(
    parameter int  WORD_SIZE  = `WORD_SIZE,
    parameter int  COUNT      = `NUM_REGISTERS,
    parameter int  READ_PORTS = 2,
    parameter int  ZERO_REG   = 0,
    localparam int COUNT_BITS = $clog2(COUNT),
    localparam int CNT_BITS   = $clog2(COUNT + 1)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr_en,
    input  logic [COUNT_BITS-1:0]              wr_idx,
    input  logic [WORD_SIZE-1:0]               wr_data,
    input  logic                               rsv_en,
    input  logic [COUNT_BITS-1:0]              rsv_idx,
    output logic                               rsv_ready,
    input  logic [READ_PORTS*COUNT_BITS-1:0]   rd_idx,
    output logic [READ_PORTS*WORD_SIZE-1:0]    rd_data,
    output logic [READ_PORTS-1:0]              rd_busy,
    output logic [CNT_BITS-1:0]                pending_count
);

    localparam logic [COUNT_BITS:0]   COUNT_EXT = (COUNT_BITS + 1)'(COUNT);
    localparam logic [COUNT_BITS-1:0] IDX_ZERO  = {COUNT_BITS{1'b0}};
    localparam bit                    ZERO_EN   = (ZERO_REG != 0);

    // An index is live when it addresses a real, writable register.
    function automatic logic idx_live(input logic [COUNT_BITS-1:0] idx);
        return ({1'b0, idx} < COUNT_EXT) && !(ZERO_EN && (idx == IDX_ZERO));
    endfunction

    logic [WORD_SIZE-1:0]  data_q [COUNT];
    logic [WORD_SIZE-1:0]  data_d [COUNT];
    logic [COUNT-1:0]      busy_q;
    logic [COUNT-1:0]      busy_d;
    logic [CNT_BITS-1:0]   cnt_q;
    logic [CNT_BITS-1:0]   cnt_d;

    logic                  wr_live_s;
    logic                  wr_busy_s;
    logic                  rsv_live_s;
    logic                  rsv_busy_s;
    logic                  rsv_ready_s;
    logic                  rsv_acc_s;
    logic                  same_idx_s;
    logic                  cnt_inc_s;
    logic                  cnt_dec_s;
    logic [COUNT-1:0]      wr_hit_s;
    logic [COUNT-1:0]      rsv_hit_s;

    logic [COUNT_BITS-1:0] rd_sel_s [READ_PORTS];
    logic [READ_PORTS-1:0] byp_hit_s;

    // Scoreboard decode: reservation acceptance and pending-counter deltas.
    always_comb begin
        wr_live_s  = wr_en & idx_live(wr_idx);
        rsv_live_s = idx_live(rsv_idx);
        same_idx_s = (wr_idx == rsv_idx);
        if (wr_live_s) begin
            wr_busy_s = busy_q[wr_idx];
        end else begin
            wr_busy_s = 1'b0;
        end
        if (rsv_live_s) begin
            rsv_busy_s = busy_q[rsv_idx];
        end else begin
            rsv_busy_s = 1'b0;
        end
        rsv_ready_s = ~rsv_busy_s | (wr_en & same_idx_s);
        rsv_acc_s   = rsv_en & rsv_ready_s & rsv_live_s;
        cnt_inc_s   = rsv_acc_s & ~rsv_busy_s;
        // A write that clears a bit re-set by a same-index reservation is not a release.
        cnt_dec_s   = wr_live_s & wr_busy_s & ~(rsv_acc_s & same_idx_s);
        cnt_d       = cnt_q + CNT_BITS'(cnt_inc_s) - CNT_BITS'(cnt_dec_s);
    end

    // Per-register next state; a same-cycle reservation overrides the write's busy clear.
    always_comb begin
        for (int i = 0; i < COUNT; i++) begin
            wr_hit_s[i]  = wr_live_s & (wr_idx == COUNT_BITS'(i));
            rsv_hit_s[i] = rsv_acc_s & (rsv_idx == COUNT_BITS'(i));
            if (wr_hit_s[i]) begin
                data_d[i] = wr_data;
            end else begin
                data_d[i] = data_q[i];
            end
            if (rsv_hit_s[i]) begin
                busy_d[i] = 1'b1;
            end else if (wr_hit_s[i]) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < COUNT; i++) begin
                data_q[i] <= {WORD_SIZE{1'b0}};
            end
            busy_q <= {COUNT{1'b0}};
            cnt_q  <= {CNT_BITS{1'b0}};
        end else begin
            for (int i = 0; i < COUNT; i++) begin
                data_q[i] <= data_d[i];
            end
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Combinational read ports, with optional forwarding of the in-flight write.
    always_comb begin
        rd_data = {(READ_PORTS*WORD_SIZE){1'b0}};
        rd_busy = {READ_PORTS{1'b0}};
        for (int p = 0; p < READ_PORTS; p++) begin
            rd_sel_s[p] = rd_idx[p*COUNT_BITS +: COUNT_BITS];
`ifdef REGFILE_BYPASS_EN
            byp_hit_s[p] = wr_live_s & (wr_idx == rd_sel_s[p]);
`else
            byp_hit_s[p] = 1'b0;
`endif
            if (byp_hit_s[p]) begin
                rd_data[p*WORD_SIZE +: WORD_SIZE] = wr_data;
                rd_busy[p]                        = 1'b0;
            end else if (idx_live(rd_sel_s[p])) begin
                rd_data[p*WORD_SIZE +: WORD_SIZE] = data_q[rd_sel_s[p]];
                rd_busy[p]                        = busy_q[rd_sel_s[p]];
            end else begin
                rd_data[p*WORD_SIZE +: WORD_SIZE] = {WORD_SIZE{1'b0}};
                rd_busy[p]                        = 1'b0;
            end
        end
    end

    assign rsv_ready     = rsv_ready_s;
    assign pending_count = cnt_q;

endmodule
